ttl_mux_scan: RTL and testbench

- Parametrised, registered N-channel, W-bit multiplexer.
- Generalises the dual 4:1 selector to any channel count and width.
- Adds a clocked output register, enable/hold, and an auto-scan mode that steps through the channels on its own, for example for time-multiplexed display or bus sampling.
- Sits between multiple register/bus sources and a single shared consumer in the TTL-CPU datapath.

---
 rtl/ttl_mux_scan_pkg.sv | 20 ++
 rtl/ttl_mux_scan_ctr.sv | 56 +++++
 rtl/ttl_mux_scan.sv | 87 ++++++++
 tb/tb_ttl_mux_scan.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ttl_mux_scan_pkg.sv
// Shared definitions for the registered N-channel scanning multiplexer.
// Holds the mode encoding and the select-width helper used by both modules.
package ttl_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_t;

  // Bits needed to index n items; never less than one so a 1-entry range still has a port.
  function automatic int sel_w(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ttl_mux_scan_ctr.sv
// Scan pointer and dwell counter for ttl_mux_scan, plus the wrap indication.
// The top presents channel 'ptr' and registers wrap_next into its Wrap output.
module ttl_mux_scan_ctr
  import ttl_mux_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1,
  localparam int SEL_W   = sel_w(CHANNELS),
  localparam int DW_W    = sel_w(DWELL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             clear,
  input  logic             adv_en,
  output logic [SEL_W-1:0] ptr,
  output logic             wrap_next
);

  logic [DW_W-1:0]  dwell;
  logic [SEL_W-1:0] cur_ptr;
  logic [SEL_W-1:0] ptr_next;
  logic [DW_W-1:0]  cur_dwell;
  logic [DW_W-1:0]  dwell_next;

  // clear with adv_en steps from zero, so scan entry counts as the first dwell cycle of channel 0.
  always_comb begin
    cur_ptr    = clear ? '0 : ptr;
    cur_dwell  = clear ? '0 : dwell;
    ptr_next   = cur_ptr;
    dwell_next = cur_dwell;
    if (adv_en) begin
      if (cur_dwell == DW_W'(DWELL - 1)) begin
        dwell_next = '0;
        if (cur_ptr == SEL_W'(CHANNELS - 1)) ptr_next = '0;
        else                                 ptr_next = cur_ptr + SEL_W'(1);
      end else begin
        dwell_next = cur_dwell + DW_W'(1);
      end
    end
  end

  // In steady scan, a zeroed pointer and dwell only occur right after a wrap.
  assign wrap_next = adv_en && !clear && (ptr == '0) && (dwell == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      dwell <= '0;
    end else if (En) begin
      ptr   <= ptr_next;
      dwell <= dwell_next;
    end
  end

endmodule

// File: rtl/ttl_mux_scan.sv
// Registered N-channel, W-bit multiplexer with enable/hold and an auto-scan mode.
// Direct mode follows S; scan mode steps channels, each held for DWELL enabled cycles.
module ttl_mux_scan
  import ttl_mux_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1,
  localparam int SEL_W   = sel_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      En,
  input  logic                      Scan,
  input  logic [SEL_W-1:0]          S,
  input  logic [CHANNELS*WIDTH-1:0] In,
  output logic [WIDTH-1:0]          Out,
  output logic [SEL_W-1:0]          Ch,
  output logic                      Wrap
);

  mode_t            mode;
  mode_t            mode_next;
  logic             entry;
  logic             clear;
  logic             adv_en;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] sel;
  logic             wrap_next;
  logic [WIDTH-1:0] mux_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode <= MODE_DIRECT;
    else       mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    if (En) mode_next = Scan ? MODE_SCAN : MODE_DIRECT;
  end

  // Direct mode keeps the counter cleared so a later scan always starts at channel 0.
  always_comb begin
    entry  = Scan && (mode == MODE_DIRECT);
    clear  = !Scan || entry;
    adv_en = Scan;
    if (!Scan)     sel = S;
    else if (entry) sel = '0;
    else            sel = ptr;
  end

  ttl_mux_scan_ctr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .En        (En),
    .clear     (clear),
    .adv_en    (adv_en),
    .ptr       (ptr),
    .wrap_next (wrap_next)
  );

  // Selects beyond the last channel (non-power-of-2 counts) read as zero.
  always_comb begin
    mux_data = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == SEL_W'(k)) mux_data = In[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Out  <= '0;
      Ch   <= '0;
      Wrap <= 1'b0;
    end else if (En) begin
      Out  <= mux_data;
      Ch   <= sel;
      Wrap <= wrap_next;
    end else begin
      Wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ttl_mux_scan.sv
// Directed bench for ttl_mux_scan: three instances cover DWELL=1, DWELL=3 and CHANNELS=3.
// Each task drives one scenario and compares against hand-computed values.
module tb_ttl_mux_scan;

  logic clk = 1'b0;
  logic reset;

  logic       en0, scan0;
  logic [1:0] s0;
  logic [7:0] in0;
  logic [1:0] out0, ch0;
  logic       wrap0;

  logic       en1, scan1;
  logic [1:0] s1;
  logic [7:0] in1;
  logic [1:0] out1, ch1;
  logic       wrap1;

  logic       en2, scan2;
  logic [1:0] s2;
  logic [5:0] in2;
  logic [1:0] out2, ch2;
  logic       wrap2;

  int errors = 0;
  int checks = 0;

  ttl_mux_scan #(.WIDTH(2), .CHANNELS(4), .DWELL(1)) dut0 (
    .clk(clk), .reset(reset), .En(en0), .Scan(scan0), .S(s0), .In(in0),
    .Out(out0), .Ch(ch0), .Wrap(wrap0)
  );

  ttl_mux_scan #(.WIDTH(2), .CHANNELS(4), .DWELL(3)) dut1 (
    .clk(clk), .reset(reset), .En(en1), .Scan(scan1), .S(s1), .In(in1),
    .Out(out1), .Ch(ch1), .Wrap(wrap1)
  );

  ttl_mux_scan #(.WIDTH(2), .CHANNELS(3), .DWELL(1)) dut2 (
    .clk(clk), .reset(reset), .En(en2), .Scan(scan2), .S(s2), .In(in2),
    .Out(out2), .Ch(ch2), .Wrap(wrap2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en0 = 0; scan0 = 0; s0 = 0; in0 = 8'h00;
    en1 = 0; scan1 = 0; s1 = 0; in1 = 8'h00;
    en2 = 0; scan2 = 0; s2 = 0; in2 = 6'h00;
    #2;
    checks++; if (out0 !== 2'd0) begin errors++; $display("FAIL reset_out0: got %0d expected 0", out0); end
    checks++; if (ch0 !== 2'd0) begin errors++; $display("FAIL reset_ch0: got %0d expected 0", ch0); end
    checks++; if (wrap0 !== 1'b0) begin errors++; $display("FAIL reset_wrap0: got %0b expected 0", wrap0); end
    checks++; if (out1 !== 2'd0 || ch1 !== 2'd0 || wrap1 !== 1'b0) begin
      errors++; $display("FAIL reset_dut1: got out=%0d ch=%0d wrap=%0b expected 0/0/0", out1, ch1, wrap1);
    end
    checks++; if (out2 !== 2'd0 || ch2 !== 2'd0 || wrap2 !== 1'b0) begin
      errors++; $display("FAIL reset_dut2: got out=%0d ch=%0d wrap=%0b expected 0/0/0", out2, ch2, wrap2);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_direct();
    en0 = 1; scan0 = 0; s0 = 2'd2; in0 = 8'he4;
    tick();
    checks++; if (out0 !== 2'd2) begin errors++; $display("FAIL direct_out_s2: got %0d expected 2", out0); end
    checks++; if (ch0 !== 2'd2) begin errors++; $display("FAIL direct_ch_s2: got %0d expected 2", ch0); end
    checks++; if (wrap0 !== 1'b0) begin errors++; $display("FAIL direct_wrap: got %0b expected 0", wrap0); end
    s0 = 2'd3;
    tick();
    checks++; if (out0 !== 2'd3 || ch0 !== 2'd3) begin
      errors++; $display("FAIL direct_s3: got out=%0d ch=%0d expected 3/3", out0, ch0);
    end
  endtask

  task automatic test_hold();
    en0 = 0; s0 = 2'd0; in0 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out0 !== 2'd3 || ch0 !== 2'd3) begin
        errors++; $display("FAIL hold_cycle%0d: got out=%0d ch=%0d expected 3/3", i, out0, ch0);
      end
    end
    en0 = 1; s0 = 2'd1; in0 = 8'he4;
    tick();
    checks++; if (out0 !== 2'd1 || ch0 !== 2'd1) begin
      errors++; $display("FAIL hold_reenable: got out=%0d ch=%0d expected 1/1", out0, ch0);
    end
  endtask

  task automatic test_scan_dwell1();
    logic [1:0] exp_ch [9];
    logic       exp_wrap [9];
    exp_ch   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    en0 = 1; scan0 = 1; in0 = 8'he4;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (ch0 !== exp_ch[i] || out0 !== exp_ch[i] || wrap0 !== exp_wrap[i]) begin
        errors++;
        $display("FAIL scan1_cycle%0d: got ch=%0d out=%0d wrap=%0b expected ch=%0d out=%0d wrap=%0b",
                 i + 1, ch0, out0, wrap0, exp_ch[i], exp_ch[i], exp_wrap[i]);
      end
    end
  endtask

  task automatic test_scan_exit();
    tick();
    tick();
    checks++; if (ch0 !== 2'd2) begin errors++; $display("FAIL exit_pre_ch: got %0d expected 2", ch0); end
    scan0 = 0; s0 = 2'd1;
    tick();
    checks++; if (out0 !== 2'd1 || ch0 !== 2'd1) begin
      errors++; $display("FAIL exit_direct: got out=%0d ch=%0d expected 1/1", out0, ch0);
    end
    scan0 = 1;
    tick();
    checks++; if (ch0 !== 2'd0 || out0 !== 2'd0 || wrap0 !== 1'b0) begin
      errors++; $display("FAIL exit_restart: got ch=%0d out=%0d wrap=%0b expected 0/0/0", ch0, out0, wrap0);
    end
    tick();
    checks++; if (ch0 !== 2'd1) begin errors++; $display("FAIL exit_restart_next: got %0d expected 1", ch0); end
  endtask

  task automatic test_dwell3();
    logic       en_pat [16];
    logic [1:0] exp_ch [16];
    logic       exp_wrap [16];
    en_pat   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_ch   = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
    exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    scan1 = 1; in1 = 8'he4;
    for (int i = 0; i < 16; i++) begin
      en1 = en_pat[i];
      tick();
      checks++; if (ch1 !== exp_ch[i] || out1 !== exp_ch[i] || wrap1 !== exp_wrap[i]) begin
        errors++;
        $display("FAIL dwell3_cycle%0d: got ch=%0d out=%0d wrap=%0b expected ch=%0d out=%0d wrap=%0b",
                 i + 1, ch1, out1, wrap1, exp_ch[i], exp_ch[i], exp_wrap[i]);
      end
    end
    en1 = 0;
  endtask

  task automatic test_nonpow2();
    en2 = 1; scan2 = 0; in2 = 6'h24; s2 = 2'd3;
    tick();
    checks++; if (out2 !== 2'd0 || ch2 !== 2'd3) begin
      errors++; $display("FAIL np2_s3: got out=%0d ch=%0d expected 0/3", out2, ch2);
    end
    s2 = 2'd2;
    tick();
    checks++; if (out2 !== 2'd2 || ch2 !== 2'd2) begin
      errors++; $display("FAIL np2_s2: got out=%0d ch=%0d expected 2/2", out2, ch2);
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp_out [4];
    logic [1:0] exp_ch [4];
    logic       exp_wrap [4];
    exp_out  = '{2'd2, 2'd3, 2'd1, 2'd2};
    exp_ch   = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_wrap = '{1'b0, 1'b0, 1'b0, 1'b1};
    en2 = 1; scan2 = 1; in2 = 6'h1e;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out2 !== exp_out[i] || ch2 !== exp_ch[i] || wrap2 !== exp_wrap[i]) begin
        errors++;
        $display("FAIL np2_scan_cycle%0d: got out=%0d ch=%0d wrap=%0b expected out=%0d ch=%0d wrap=%0b",
                 i + 1, out2, ch2, wrap2, exp_out[i], exp_ch[i], exp_wrap[i]);
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (out2 !== 2'd0 || ch2 !== 2'd0 || wrap2 !== 1'b0) begin
      errors++; $display("FAIL async_reset: got out=%0d ch=%0d wrap=%0b expected 0/0/0", out2, ch2, wrap2);
    end
    #2 reset = 1'b0;
    tick();
    checks++; if (out2 !== 2'd2 || ch2 !== 2'd0 || wrap2 !== 1'b0) begin
      errors++; $display("FAIL post_reset_entry: got out=%0d ch=%0d wrap=%0b expected 2/0/0", out2, ch2, wrap2);
    end
    tick();
    checks++; if (out2 !== 2'd3 || ch2 !== 2'd1) begin
      errors++; $display("FAIL post_reset_next: got out=%0d ch=%0d expected 3/1", out2, ch2);
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_hold();
    test_scan_dwell1();
    test_scan_exit();
    test_dwell3();
    test_nonpow2();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
